pc_redirect: RTL and testbench

Fetch-side PC generator that consumes the EX-stage branch decision (should_branch) and jump decodes.
It computes the redirect target, updates the fetch PC, and squashes wrong-path instructions with a registered flush window.
It holds a resolved redirect across stalls and fetch back-pressure so no redirect is ever lost.
It sits between the EX-stage branch comparator and the instruction-fetch stage.

---
 rtl/pc_redirect.sv | 146 ++++++++++++++
 tb/tb_pc_redirect.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect.sv
// rtl/pc_redirect.sv - fetch PC generator with branch/jump redirect, hold and flush window
module pc_redirect #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_branch,
  input  logic        should_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        redirect_pending,
  output logic        misaligned
);

  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             pend_q, pend_d;
  logic             mis_q, mis_d;

  logic        take;
  logic        advance;
  logic [31:0] target;
  logic        target_bad;
  logic [31:0] pc_seq;

  // Resolve the EX-stage redirect: JALR has priority, branch and JAL share ex_pc + imm
  always_comb begin
    take    = is_jalr | is_jal | (is_branch & should_branch);
    advance = !stall & fetch_ready;
    pc_seq  = pc_q + 32'd4;
    if (is_jalr) begin
      target     = (rs1 + imm) & ~32'h1;
      target_bad = target[1];
    end else begin
      target     = ex_pc + imm;
      target_bad = target[1] | target[0];
    end
  end

  // Next-state logic; take inputs only matter in RUN, everything else is a squashed slot
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    pend_d  = pend_q;
    mis_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (take && !target_bad) begin
          if (advance) begin
            pc_d    = target;
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
            flush_d = 1'b1;
          end else begin
            tgt_d   = target;
            pend_d  = 1'b1;
            state_d = HOLD;
          end
        end else begin
          mis_d = take & target_bad;
          if (advance) pc_d = pc_seq;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d    = tgt_q;
          pend_d  = 1'b0;
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        if (advance) pc_d = pc_seq;
        // Only un-stalled cycles retire a squashed slot
        if (!stall) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            flush_d = 1'b0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        flush_d = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any held redirect or flush window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      pend_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

  assign pc               = pc_q;
  assign flush            = flush_q;
  assign redirect_pending = pend_q;
  assign misaligned       = mis_q;
  assign fetch_valid      = rst_n & (state_q != HOLD) & !stall;

endmodule

// File: tb/tb_pc_redirect.sv
// tb/tb_pc_redirect.sv - directed self-checking bench for pc_redirect
module tb_pc_redirect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_branch, should_branch, is_jal, is_jalr;
  logic [31:0] ex_pc, imm, rs1;
  logic        stall, fetch_ready;
  logic [31:0] pc;
  logic        fetch_valid, flush, redirect_pending, misaligned;

  int tests = 0;
  int fails = 0;

  pc_redirect #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .is_branch(is_branch), .should_branch(should_branch),
    .is_jal(is_jal), .is_jalr(is_jalr),
    .ex_pc(ex_pc), .imm(imm), .rs1(rs1),
    .stall(stall), .fetch_ready(fetch_ready),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush),
    .redirect_pending(redirect_pending), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_take();
    is_branch = 0; should_branch = 0; is_jal = 0; is_jalr = 0;
    ex_pc = 0; imm = 0; rs1 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_take(); stall = 0; fetch_ready = 1;
    step(); step();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    tests++; if (flush !== 1'b0 || redirect_pending !== 1'b0 || misaligned !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b%b want 000", flush, redirect_pending, misaligned); end
    tests++; if (fetch_valid !== 1'b0) begin fails++; $display("FAIL reset_fv_low got %b want 0", fetch_valid); end
    rst_n = 1; #1;
    tests++; if (fetch_valid !== 1'b1) begin fails++; $display("FAIL reset_fv_release got %b want 1", fetch_valid); end
    step(); tests++; if (pc !== 32'h4) begin fails++; $display("FAIL reset_seq4 got %h want %h", pc, 32'h4); end
    step(); tests++; if (pc !== 32'h8) begin fails++; $display("FAIL reset_seq8 got %h want %h", pc, 32'h8); end
    step(); tests++; if (pc !== 32'hC) begin fails++; $display("FAIL reset_seqC got %h want %h", pc, 32'hC); end
  endtask

  task automatic test_taken_branch();
    is_branch = 1; should_branch = 1; ex_pc = 32'h100; imm = 32'h40;
    step();
    tests++; if (pc !== 32'h140 || flush !== 1'b1) begin fails++; $display("FAIL br_target got pc=%h fl=%b want 140/1", pc, flush); end
    clear_take(); is_jal = 1; ex_pc = 32'h300; imm = 32'h0;
    step();
    tests++; if (pc !== 32'h144 || flush !== 1'b1) begin fails++; $display("FAIL br_flush2 got pc=%h fl=%b want 144/1", pc, flush); end
    clear_take();
    step();
    tests++; if (pc !== 32'h148 || flush !== 1'b0) begin fails++; $display("FAIL br_flush_end got pc=%h fl=%b want 148/0", pc, flush); end
    step();
    tests++; if (pc !== 32'h14C || flush !== 1'b0) begin fails++; $display("FAIL br_after got pc=%h fl=%b want 14c/0", pc, flush); end
  endtask

  task automatic test_not_taken();
    is_branch = 1; should_branch = 0; ex_pc = 32'h100; imm = 32'h40;
    step();
    tests++; if (pc !== 32'h150 || flush !== 1'b0) begin fails++; $display("FAIL nt_1 got pc=%h fl=%b want 150/0", pc, flush); end
    step();
    tests++; if (pc !== 32'h154 || flush !== 1'b0) begin fails++; $display("FAIL nt_2 got pc=%h fl=%b want 154/0", pc, flush); end
    clear_take();
  endtask

  task automatic test_jalr_align();
    is_jalr = 1; rs1 = 32'h203; imm = 32'h0;
    step();
    tests++; if (pc !== 32'h158 || misaligned !== 1'b1 || flush !== 1'b0) begin fails++; $display("FAIL jalr_mis got pc=%h mis=%b fl=%b want 158/1/0", pc, misaligned, flush); end
    clear_take();
    step();
    tests++; if (pc !== 32'h15C || misaligned !== 1'b0) begin fails++; $display("FAIL jalr_mis_pulse got pc=%h mis=%b want 15c/0", pc, misaligned); end
    is_jalr = 1; rs1 = 32'h201; imm = 32'h3;
    step();
    tests++; if (pc !== 32'h204 || flush !== 1'b1 || misaligned !== 1'b0) begin fails++; $display("FAIL jalr_ok got pc=%h fl=%b mis=%b want 204/1/0", pc, flush, misaligned); end
    clear_take();
    step();
    tests++; if (pc !== 32'h208 || flush !== 1'b1) begin fails++; $display("FAIL jalr_fl2 got pc=%h fl=%b want 208/1", pc, flush); end
    step();
    tests++; if (pc !== 32'h20C || flush !== 1'b0) begin fails++; $display("FAIL jalr_fl_end got pc=%h fl=%b want 20c/0", pc, flush); end
  endtask

  task automatic test_stall_redirect();
    is_jal = 1; ex_pc = 32'h80; imm = 32'h20; stall = 1;
    step();
    tests++; if (redirect_pending !== 1'b1 || pc !== 32'h20C || fetch_valid !== 1'b0) begin fails++; $display("FAIL st_hold got pend=%b pc=%h fv=%b want 1/20c/0", redirect_pending, pc, fetch_valid); end
    clear_take();
    step(); step();
    tests++; if (redirect_pending !== 1'b1 || pc !== 32'h20C || flush !== 1'b0) begin fails++; $display("FAIL st_hold3 got pend=%b pc=%h fl=%b want 1/20c/0", redirect_pending, pc, flush); end
    stall = 0; #1;
    tests++; if (fetch_valid !== 1'b0) begin fails++; $display("FAIL st_hold_fv got %b want 0", fetch_valid); end
    step();
    tests++; if (pc !== 32'hA0 || redirect_pending !== 1'b0 || flush !== 1'b1 || fetch_valid !== 1'b1) begin fails++; $display("FAIL st_release got pc=%h pend=%b fl=%b fv=%b want a0/0/1/1", pc, redirect_pending, flush, fetch_valid); end
    stall = 1;
    step();
    tests++; if (pc !== 32'hA0 || flush !== 1'b1) begin fails++; $display("FAIL st_flush_stall got pc=%h fl=%b want a0/1", pc, flush); end
    stall = 0;
    step();
    tests++; if (pc !== 32'hA4 || flush !== 1'b1) begin fails++; $display("FAIL st_flush_ext got pc=%h fl=%b want a4/1", pc, flush); end
    step();
    tests++; if (pc !== 32'hA8 || flush !== 1'b0) begin fails++; $display("FAIL st_flush_end got pc=%h fl=%b want a8/0", pc, flush); end
  endtask

  task automatic test_backpressure();
    fetch_ready = 0;
    step();
    tests++; if (pc !== 32'hA8 || fetch_valid !== 1'b1) begin fails++; $display("FAIL bp_hold got pc=%h fv=%b want a8/1", pc, fetch_valid); end
    is_jal = 1; ex_pc = 32'h40; imm = 32'h0;
    step();
    tests++; if (redirect_pending !== 1'b1 || pc !== 32'hA8) begin fails++; $display("FAIL bp_pend got pend=%b pc=%h want 1/a8", redirect_pending, pc); end
    clear_take(); fetch_ready = 1;
    step();
    tests++; if (pc !== 32'h40 || flush !== 1'b1 || redirect_pending !== 1'b0) begin fails++; $display("FAIL bp_release got pc=%h fl=%b pend=%b want 40/1/0", pc, flush, redirect_pending); end
    step(); step();
  endtask

  task automatic test_wrap();
    is_jal = 1; ex_pc = 32'hFFFF_FFF0; imm = 32'hC;
    step();
    tests++; if (pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_tgt got %h want fffffffc", pc); end
    clear_take();
    step();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_zero got %h want 0", pc); end
    step();
    tests++; if (pc !== 32'h4 || flush !== 1'b0) begin fails++; $display("FAIL wrap_after got pc=%h fl=%b want 4/0", pc, flush); end
  endtask

  task automatic test_reset_in_hold();
    is_jal = 1; ex_pc = 32'h80; imm = 32'h20; stall = 1;
    step();
    tests++; if (redirect_pending !== 1'b1) begin fails++; $display("FAIL rh_pend got %b want 1", redirect_pending); end
    clear_take(); rst_n = 0;
    step();
    tests++; if (pc !== 32'h0 || redirect_pending !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL rh_reset got pc=%h pend=%b fl=%b want 0/0/0", pc, redirect_pending, flush); end
    rst_n = 1; stall = 0;
    step();
    tests++; if (pc !== 32'h4 || flush !== 1'b0 || redirect_pending !== 1'b0) begin fails++; $display("FAIL rh_discard got pc=%h fl=%b pend=%b want 4/0/0", pc, flush, redirect_pending); end
  endtask

  task automatic test_priority();
    is_jal = 1; is_branch = 1; should_branch = 0; ex_pc = 32'h500; imm = 32'h20;
    step();
    tests++; if (pc !== 32'h520 || flush !== 1'b1) begin fails++; $display("FAIL pri_jal got pc=%h fl=%b want 520/1", pc, flush); end
    clear_take(); step(); step();
    tests++; if (pc !== 32'h528 || flush !== 1'b0) begin fails++; $display("FAIL pri_jal_after got pc=%h fl=%b want 528/0", pc, flush); end
    is_jalr = 1; is_jal = 1; rs1 = 32'h600; ex_pc = 32'h500; imm = 32'h10;
    step();
    tests++; if (pc !== 32'h610) begin fails++; $display("FAIL pri_jalr got %h want 610", pc); end
    clear_take(); step(); step();
    tests++; if (pc !== 32'h618 || flush !== 1'b0) begin fails++; $display("FAIL pri_jalr_after got pc=%h fl=%b want 618/0", pc, flush); end
  endtask

  task automatic test_reset_vs_take();
    is_jal = 1; ex_pc = 32'h700; imm = 32'h0; rst_n = 0;
    step();
    tests++; if (pc !== 32'h0 || flush !== 1'b0 || redirect_pending !== 1'b0) begin fails++; $display("FAIL rt_reset got pc=%h fl=%b pend=%b want 0/0/0", pc, flush, redirect_pending); end
    clear_take(); rst_n = 1;
    step();
    tests++; if (pc !== 32'h4 || flush !== 1'b0) begin fails++; $display("FAIL rt_after got pc=%h fl=%b want 4/0", pc, flush); end
  endtask

  initial begin
    test_reset();
    test_taken_branch();
    test_not_taken();
    test_jalr_align();
    test_stall_redirect();
    test_backpressure();
    test_wrap();
    test_reset_in_hold();
    test_priority();
    test_reset_vs_take();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
